rom_arbiter: RTL and testbench



---
 rtl/rom_arb_pkg.sv | 21 ++
 rtl/rom_lut.sv | 22 ++
 rtl/rom_arbiter.sv | 115 +++++++++++
 tb/tb_rom_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the ROM arbiter slice: FSM states,
// default widths and the fixed lookup-table contents.
package rom_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam int DEF_NREQ   = 2;
    localparam int DEF_ADDR_W = 2;
    localparam int DEF_DATA_W = 4;
    localparam int DEF_CNT_W  = 8;

    localparam int ROM_DEPTH = 4;

    // Entry i sits at index [i], so ROM_DATA[0] = 3 and ROM_DATA[3] = C.
    localparam logic [ROM_DEPTH-1:0][3:0] ROM_DATA = {4'hC, 4'h9, 4'h6, 4'h3};

endpackage

// File: rtl/rom_lut.sv
// Combinational lookup of the shared 4-entry ROM.
// Addresses beyond the table read as zero.
module rom_lut
    import rom_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    always_comb begin
        data = '0;
        for (int i = 0; i < ROM_DEPTH; i++) begin
            if (int'(addr) == i) begin
                data = DATA_W'(ROM_DATA[i]);
            end
        end
    end

endmodule

// File: rtl/rom_arbiter.sv
// Round-robin arbiter giving NREQ requesters one-at-a-time access to the
// lookup ROM, with registered grant/data/strobe and per-requester counters.
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int NREQ   = DEF_NREQ,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                        clk_2,
    input  logic                        rst_n,
    input  logic [NREQ-1:0]             req,
    input  logic [NREQ-1:0][ADDR_W-1:0] addr,
    output logic [NREQ-1:0]             gnt,
    output logic [NREQ-1:0]             rvalid,
    output logic [DATA_W-1:0]           rdata,
    output logic                        busy,
    output logic [NREQ-1:0][CNT_W-1:0]  gnt_cnt
);

    localparam int OWN_W = $clog2(NREQ);

    arb_state_t        state;
    arb_state_t        state_nx;
    logic [OWN_W-1:0]  ptr;
    logic [OWN_W-1:0]  owner;
    logic [OWN_W-1:0]  winner;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] lut_data;

    // Descending scan so the requester closest to ptr (upward, wrapping) wins.
    function automatic logic [OWN_W-1:0] pick_winner(input logic [NREQ-1:0] r,
                                                     input logic [OWN_W-1:0] p);
        logic [OWN_W-1:0] w;
        int idx;
        w = p;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(p) + k) % NREQ;
            if (r[idx]) begin
                w = OWN_W'(idx);
            end
        end
        return w;
    endfunction

    assign winner = pick_winner(req, ptr);

    rom_lut #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_lut (
        .addr (addr_q),
        .data (lut_data)
    );

    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (|req) state_nx = READ;
            READ:    state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // The round-robin pointer only advances once a transaction fully completes,
    // so a reset mid-transaction leaves priority back at requester 0.
    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            gnt     <= '0;
            rvalid  <= '0;
            rdata   <= '0;
            busy    <= 1'b0;
            gnt_cnt <= '0;
            owner   <= '0;
            addr_q  <= '0;
            ptr     <= '0;
        end else begin
            busy <= (state_nx != IDLE);
            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt    <= NREQ'(1) << winner;
                        owner  <= winner;
                        addr_q <= addr[winner];
                    end
                end
                READ: begin
                    gnt    <= '0;
                    rdata  <= lut_data;
                    rvalid <= NREQ'(1) << owner;
                end
                RESP: begin
                    rvalid         <= '0;
                    gnt_cnt[owner] <= gnt_cnt[owner] + CNT_W'(1);
                    ptr            <= (int'(owner) == NREQ - 1) ? '0 : owner + 1'b1;
                end
                default: begin
                    gnt    <= '0;
                    rvalid <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter: transaction-timing reference model
// compared every cycle, directed scenarios with literal expectations, then random traffic.
module tb_rom_arbiter;

    localparam int NREQ   = 2;
    localparam int ADDR_W = 2;
    localparam int DATA_W = 4;
    localparam int CNT_W  = 8;

    logic                        clk_2;
    logic                        rst_n;
    logic [NREQ-1:0]             req;
    logic [NREQ-1:0][ADDR_W-1:0] addr;
    logic [NREQ-1:0]             gnt;
    logic [NREQ-1:0]             rvalid;
    logic [DATA_W-1:0]           rdata;
    logic                        busy;
    logic [NREQ-1:0][CNT_W-1:0]  gnt_cnt;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    rom_arbiter #(
        .NREQ   (NREQ),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk_2   (clk_2),
        .rst_n   (rst_n),
        .req     (req),
        .addr    (addr),
        .gnt     (gnt),
        .rvalid  (rvalid),
        .rdata   (rdata),
        .busy    (busy),
        .gnt_cnt (gnt_cnt)
    );

    initial clk_2 = 1'b0;
    always #5 clk_2 = ~clk_2;

    // Reference model: a transaction sampled at edge e shows gnt after e,
    // rvalid/rdata after e+1, the counter bump after e+2; next sample at e+3.
    int               edge_no;
    int               next_sample;
    int               txn_edge;
    int               txn_owner;
    int               txn_addr;
    int               mptr;
    logic [NREQ-1:0]  m_gnt;
    logic [NREQ-1:0]  m_rvalid;
    logic [DATA_W-1:0] m_rdata;
    logic             m_busy;
    logic [CNT_W-1:0] m_cnt [NREQ];

    always @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            edge_no     = 0;
            next_sample = 0;
            txn_edge    = -10;
            txn_owner   = 0;
            txn_addr    = 0;
            mptr        = 0;
            m_gnt       = '0;
            m_rvalid    = '0;
            m_rdata     = '0;
            m_busy      = 1'b0;
            for (int i = 0; i < NREQ; i++) m_cnt[i] = '0;
        end else begin
            if (edge_no >= next_sample && req != '0) begin
                int found;
                found = -1;
                for (int k = 0; k < NREQ; k++) begin
                    if (found < 0 && req[(mptr + k) % NREQ]) found = (mptr + k) % NREQ;
                end
                txn_edge    = edge_no;
                txn_owner   = found;
                txn_addr    = int'(addr[found]);
                next_sample = edge_no + 3;
                mptr        = (found + 1) % NREQ;
            end
            m_gnt    = (edge_no == txn_edge) ? NREQ'(1 << txn_owner) : '0;
            m_rvalid = (edge_no == txn_edge + 1) ? NREQ'(1 << txn_owner) : '0;
            if (edge_no == txn_edge + 1) m_rdata = DATA_W'(3 * (txn_addr + 1));
            if (edge_no == txn_edge + 2) m_cnt[txn_owner] = m_cnt[txn_owner] + 1'b1;
            m_busy  = (edge_no == txn_edge) || (edge_no == txn_edge + 1);
            edge_no = edge_no + 1;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk_2) begin
        if (cmp_en) begin
            checkOutput("model_gnt", int'(gnt), int'(m_gnt));
            checkOutput("model_rvalid", int'(rvalid), int'(m_rvalid));
            checkOutput("model_rdata", int'(rdata), int'(m_rdata));
            checkOutput("model_busy", int'(busy), int'(m_busy));
            for (int i = 0; i < NREQ; i++) begin
                checkOutput($sformatf("model_gnt_cnt%0d", i), int'(gnt_cnt[i]), int'(m_cnt[i]));
            end
        end
    end

    task automatic applyStimulus(input logic [NREQ-1:0] r, input logic [NREQ-1:0][ADDR_W-1:0] a);
        @(negedge clk_2);
        req  = r;
        addr = a;
    endtask

    task automatic stepEdge();
        @(posedge clk_2);
        #1;
    endtask

    task automatic doReset(input logic [NREQ-1:0] r, input logic [NREQ-1:0][ADDR_W-1:0] a);
        @(negedge clk_2);
        #2;
        rst_n = 1'b0;
        req   = r;
        addr  = a;
        repeat (2) @(negedge clk_2);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [3:0] rom_tab [4];
        rom_tab = '{4'h3, 4'h6, 4'h9, 4'hC};
        rst_n = 1'b1;
        req   = '0;
        addr  = '0;
        #2;
        rst_n  = 1'b0;
        #1;
        cmp_en = 1'b1;

        // Idle after reset
        doReset('0, '0);
        repeat (5) stepEdge();
        checkOutput("idle_gnt", int'(gnt), 0);
        checkOutput("idle_rvalid", int'(rvalid), 0);
        checkOutput("idle_busy", int'(busy), 0);
        checkOutput("idle_rdata", int'(rdata), 0);
        checkOutput("idle_cnt0", int'(gnt_cnt[0]), 0);
        checkOutput("idle_cnt1", int'(gnt_cnt[1]), 0);

        // Single read by requester 0 at address 2
        applyStimulus(2'b01, {2'd0, 2'd2});
        stepEdge();
        checkOutput("single_gnt", int'(gnt), 1);
        checkOutput("single_busy1", int'(busy), 1);
        applyStimulus(2'b00, {2'd0, 2'd2});
        stepEdge();
        checkOutput("single_rvalid", int'(rvalid), 1);
        checkOutput("single_rdata", int'(rdata), 9);
        checkOutput("single_busy2", int'(busy), 1);
        stepEdge();
        checkOutput("single_busy3", int'(busy), 0);
        checkOutput("single_cnt0", int'(gnt_cnt[0]), 1);

        // Both requesting from reset, each dropping on its grant
        doReset(2'b11, {2'd3, 2'd1});
        stepEdge();
        checkOutput("both_gnt_first", int'(gnt), 1);
        applyStimulus(2'b10, {2'd3, 2'd1});
        stepEdge();
        checkOutput("both_rvalid_first", int'(rvalid), 1);
        checkOutput("both_rdata_first", int'(rdata), 6);
        stepEdge();
        stepEdge();
        checkOutput("both_gnt_second", int'(gnt), 2);
        applyStimulus(2'b00, {2'd3, 2'd1});
        stepEdge();
        checkOutput("both_rvalid_second", int'(rvalid), 2);
        checkOutput("both_rdata_second", int'(rdata), 12);
        stepEdge();
        checkOutput("both_cnt0", int'(gnt_cnt[0]), 1);
        checkOutput("both_cnt1", int'(gnt_cnt[1]), 1);

        // Both held for 12 cycles: grants alternate every 3 cycles
        doReset('0, '0);
        applyStimulus(2'b11, {2'd2, 2'd1});
        for (int k = 0; k < 12; k++) begin
            stepEdge();
            if (k % 3 == 0) checkOutput($sformatf("alt_gnt_k%0d", k), int'(gnt), (k % 6 == 0) ? 1 : 2);
        end
        applyStimulus(2'b00, {2'd2, 2'd1});
        checkOutput("alt_cnt0", int'(gnt_cnt[0]), 2);
        checkOutput("alt_cnt1", int'(gnt_cnt[1]), 2);

        // Reset asserted while in READ
        doReset('0, '0);
        applyStimulus(2'b01, {2'd0, 2'd3});
        stepEdge();
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_gnt", int'(gnt), 0);
        checkOutput("rst_rvalid", int'(rvalid), 0);
        checkOutput("rst_busy", int'(busy), 0);
        applyStimulus(2'b00, {2'd0, 2'd3});
        #2;
        rst_n = 1'b1;
        stepEdge();
        stepEdge();
        checkOutput("rst_no_rvalid", int'(rvalid), 0);
        checkOutput("rst_cnt0", int'(gnt_cnt[0]), 0);

        // Address sweep on requester 1
        doReset('0, '0);
        for (int a = 0; a < 4; a++) begin
            applyStimulus(2'b10, {ADDR_W'(a), 2'd0});
            stepEdge();
            applyStimulus(2'b00, {ADDR_W'(a), 2'd0});
            stepEdge();
            checkOutput($sformatf("sweep_rdata_a%0d", a), int'(rdata), int'(rom_tab[a]));
            stepEdge();
        end
        checkOutput("sweep_cnt1", int'(gnt_cnt[1]), 4);

        // 256 back-to-back transactions wrap the counter
        doReset('0, '0);
        applyStimulus(2'b10, {2'd3, 2'd0});
        repeat (256 * 3) stepEdge();
        applyStimulus(2'b00, {2'd3, 2'd0});
        checkOutput("wrap_cnt1", int'(gnt_cnt[1]), 0);
        checkOutput("wrap_cnt0", int'(gnt_cnt[0]), 0);

        // Random traffic with occasional resets
        doReset('0, '0);
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk_2);
            if ($urandom_range(0, 299) == 0) begin
                #2;
                rst_n = 1'b0;
                @(negedge clk_2);
                #2;
                rst_n = 1'b1;
            end else begin
                for (int i = 0; i < NREQ; i++) begin
                    if (gnt[i] && $urandom_range(0, 3) != 0) begin
                        req[i] = 1'b0;
                    end else if (!req[i] && $urandom_range(0, 2) == 0) begin
                        req[i]  = 1'b1;
                        addr[i] = ADDR_W'($urandom_range(0, 3));
                    end
                end
            end
        end
        applyStimulus('0, '0);
        repeat (4) stepEdge();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
